// File: rtl/detector_colisiones.sv
// detector_colisiones: hero FSM, obstacle pipe, collision/bonus detection and lives
// for the consumer side of the obstacle interface.
module detector_colisiones #(
   parameter logic [2:0] GAME       = 3'd3,
   parameter logic [2:0] WL         = 3'd4,
   parameter logic [1:0] VIDAS_INI  = 2'd3,
   parameter logic [1:0] JUMP_TICKS = 2'd2,
   parameter logic [1:0] INV_TICKS  = 2'd2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_obstaculos,
   input  logic [2:0]  presente,
   input  logic [1:0]  mundo,
   input  logic [4:0]  tipo_obs,
   input  logic [20:0] display_obs,
   input  logic        btn_salto,
   input  logic        btn_agachar,
   output logic        bono_tomado,
   output logic [1:0]  W_or_L,
   output logic [1:0]  vidas,
   output logic [1:0]  heroe_estado
);
   localparam logic [1:0] GROUND = 2'd0, JUMP = 2'd1, DUCK = 2'd2;
   localparam logic [1:0] NONE = 2'd0, LOW = 2'd1, HIGH = 2'd2, BONUS = 2'd3;

   logic [2:0] sinc;
   logic       salto_q, salto_pend, salto_ev, tick, pickup, hit;
   logic [1:0] pipe [3];
   logic [1:0] jcnt, icnt, nuevo, est_n;
   logic       unused_display;

   assign unused_display = ^display_obs[13:0];

   always_comb begin
      tick     = sinc[1] & ~sinc[2];
      salto_ev = salto_pend | (btn_salto & ~salto_q);
      nuevo    = mundo == 2'd3 ? NONE :
                 tipo_obs == 5'd16 ? BONUS :
                 display_obs[20:14] == 7'd0 ? NONE :
                 tipo_obs[0] ? HIGH : LOW;
      est_n    = heroe_estado == GROUND ? (salto_ev ? JUMP : btn_agachar ? DUCK : GROUND) :
                 heroe_estado == JUMP ? (jcnt == 2'd1 ? GROUND : JUMP) :
                 (btn_agachar ? DUCK : GROUND);
      // pipe[1] becomes the hero column after this tick's shift
      pickup   = pipe[1] == BONUS && mundo != 2'd3;
      hit      = (pipe[1] == LOW && est_n != JUMP) || (pipe[1] == HIGH && est_n != DUCK);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sinc         <= '0;
         salto_q      <= 1'b0;
         salto_pend   <= 1'b0;
         pipe         <= '{NONE, NONE, NONE};
         heroe_estado <= GROUND;
         jcnt         <= '0;
         icnt         <= '0;
         vidas        <= '0;
         W_or_L       <= '0;
         bono_tomado  <= 1'b0;
      end else begin
         sinc        <= {sinc[1:0], clk_obstaculos};
         salto_q     <= btn_salto;
         salto_pend  <= tick ? 1'b0 : salto_ev;
         bono_tomado <= 1'b0;
         if (presente == GAME) begin
            if (W_or_L == 2'b00 && tick) begin
               pipe         <= '{pipe[1], pipe[2], nuevo};
               heroe_estado <= est_n;
               jcnt         <= heroe_estado == JUMP ? jcnt - 2'd1 : JUMP_TICKS;
               icnt         <= icnt != 2'd0 ? icnt - 2'd1 : (hit && !pickup) ? INV_TICKS : 2'd0;
               if (pickup) begin
                  bono_tomado <= 1'b1;
                  if (mundo == 2'd2) W_or_L <= 2'b10;
               end else if (hit && icnt == 2'd0) begin
                  vidas <= vidas - 2'd1;
                  if (vidas == 2'd1) W_or_L <= 2'b01;
               end
            end
         end else if (presente != WL) begin
            pipe         <= '{NONE, NONE, NONE};
            heroe_estado <= GROUND;
            jcnt         <= '0;
            icnt         <= '0;
            vidas        <= VIDAS_INI;
            W_or_L       <= 2'b00;
         end
      end
   end
endmodule
